// File: rtl/frame_buffer_scheduler.sv
// Triple/quad-buffer scheduler: hands out frame-memory base addresses to a sensor
// writer and a display reader so the reader never sees a partially written frame.
module frame_buffer_scheduler #(
  parameter int unsigned       NUM_BUFFERS  = 3,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(32'h0004_B000)
) (
  input  logic              ul1Clock,
  input  logic              ul1Reset,
  input  logic              ul1Enable,
  input  logic              ul1WrFrameStart,
  input  logic              ul1WrFrameEnd,
  input  logic              ul1WrFrameAbort,
  output logic              ul1WrValid,
  output logic [ADDR_W-1:0] ulWrBase,
  input  logic              ul1RdFrameStart,
  output logic              ul1RdValid,
  output logic [ADDR_W-1:0] ulRdBase,
  output logic [1:0]        ul2WrIdx,
  output logic [1:0]        ul2RdIdx,
  output logic [15:0]       ul16FramesDropped,
  output logic [15:0]       ul16FramesShown
);

  typedef enum logic {W_IDLE, W_ACTIVE} wr_state_e;

  wr_state_e         state_q, state_d;
  logic              wr_valid_q, wr_valid_d;
  logic [1:0]        wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic              rd_valid_q, rd_valid_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic              ready_valid_q, ready_valid_d;
  logic [1:0]        ready_idx_q, ready_idx_d;
  logic [15:0]       dropped_q, dropped_d;
  logic [15:0]       shown_q, shown_d;
  logic              drop_inc, show_inc, found;
  logic [1:0]        sel_idx;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * FRAME_STRIDE;
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_valid_d    = wr_valid_q;
    wr_idx_d      = wr_idx_q;
    wr_base_d     = wr_base_q;
    rd_valid_d    = rd_valid_q;
    rd_idx_d      = rd_idx_q;
    rd_base_d     = rd_base_q;
    ready_valid_d = ready_valid_q;
    ready_idx_d   = ready_idx_q;
    drop_inc      = 1'b0;
    show_inc      = 1'b0;
    found         = 1'b0;
    sel_idx       = '0;

    if (ul1RdFrameStart && ready_valid_q) begin
      rd_idx_d      = ready_idx_q;
      rd_base_d     = base_of(ready_idx_q);
      rd_valid_d    = 1'b1;
      ready_valid_d = 1'b0;
      show_inc      = 1'b1;
    end

    case (state_q)
      W_ACTIVE: begin
        if (ul1WrFrameAbort) begin
          drop_inc   = 1'b1;
          wr_valid_d = 1'b0;
          state_d    = W_IDLE;
        end else if (ul1WrFrameEnd) begin
          if (ready_valid_q) drop_inc = 1'b1;
          // Bypass overrides the READY hand-off above: reader takes the fresh frame
          if (ul1RdFrameStart) begin
            rd_idx_d      = wr_idx_q;
            rd_base_d     = wr_base_q;
            rd_valid_d    = 1'b1;
            ready_valid_d = 1'b0;
            show_inc      = 1'b1;
          end else begin
            ready_idx_d   = wr_idx_q;
            ready_valid_d = 1'b1;
          end
          wr_valid_d = 1'b0;
          state_d    = W_IDLE;
        end else if (ul1WrFrameStart) begin
          drop_inc = 1'b1;
        end
      end
      W_IDLE: begin
        if (ul1WrFrameStart && ul1Enable) begin
          // Selection sees the post-update reader/READY ownership
          for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
            if (!found && !(rd_valid_d && rd_idx_d == 2'(i)) &&
                !(ready_valid_d && ready_idx_d == 2'(i))) begin
              found   = 1'b1;
              sel_idx = 2'(i);
            end
          end
          wr_idx_d   = sel_idx;
          wr_base_d  = base_of(sel_idx);
          wr_valid_d = 1'b1;
          state_d    = W_ACTIVE;
        end
      end
      default: state_d = W_IDLE;
    endcase

    dropped_d = (drop_inc && dropped_q != '1) ? dropped_q + 16'd1 : dropped_q;
    shown_d   = (show_inc && shown_q != '1) ? shown_q + 16'd1 : shown_q;
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      state_q       <= W_IDLE;
      wr_valid_q    <= 1'b0;
      wr_idx_q      <= '0;
      wr_base_q     <= BASE_ADDR;
      rd_valid_q    <= 1'b0;
      rd_idx_q      <= '0;
      rd_base_q     <= BASE_ADDR;
      ready_valid_q <= 1'b0;
      ready_idx_q   <= '0;
      dropped_q     <= '0;
      shown_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_valid_q    <= wr_valid_d;
      wr_idx_q      <= wr_idx_d;
      wr_base_q     <= wr_base_d;
      rd_valid_q    <= rd_valid_d;
      rd_idx_q      <= rd_idx_d;
      rd_base_q     <= rd_base_d;
      ready_valid_q <= ready_valid_d;
      ready_idx_q   <= ready_idx_d;
      dropped_q     <= dropped_d;
      shown_q       <= shown_d;
    end
  end

  assign ul1WrValid        = wr_valid_q;
  assign ulWrBase          = wr_base_q;
  assign ul2WrIdx          = wr_idx_q;
  assign ul1RdValid        = rd_valid_q;
  assign ulRdBase          = rd_base_q;
  assign ul2RdIdx          = rd_idx_q;
  assign ul16FramesDropped = dropped_q;
  assign ul16FramesShown   = shown_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios plus random pulses checked
// against an ownership-based reference model.
module tb_frame_buffer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        ws = 1'b0, we = 1'b0, wa = 1'b0, rs = 1'b0;
  logic        wr_valid, rd_valid;
  logic [31:0] wr_base, rd_base;
  logic [1:0]  wr_idx, rd_idx;
  logic [15:0] dropped, shown;

  int total = 0;
  int bad = 0;

  // reference model state
  bit m_active, m_rd_v, m_ready_v;
  int m_wr, m_rd, m_ready, m_drop, m_shown;

  always #5 clk = ~clk;

  frame_buffer_scheduler #(
    .NUM_BUFFERS(3),
    .ADDR_W(32),
    .BASE_ADDR(32'h0000_0000),
    .FRAME_STRIDE(32'h0004_B000)
  ) dut (
    .ul1Clock(clk),
    .ul1Reset(rst),
    .ul1Enable(en),
    .ul1WrFrameStart(ws),
    .ul1WrFrameEnd(we),
    .ul1WrFrameAbort(wa),
    .ul1WrValid(wr_valid),
    .ulWrBase(wr_base),
    .ul1RdFrameStart(rs),
    .ul1RdValid(rd_valid),
    .ulRdBase(rd_base),
    .ul2WrIdx(wr_idx),
    .ul2RdIdx(rd_idx),
    .ul16FramesDropped(dropped),
    .ul16FramesShown(shown)
  );

  function automatic logic [31:0] base_of(input int idx);
    return 32'(idx * 32'h0004_B000);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Applies one clock edge of events to the model: writer completion first, then
  // the reader taking READY, then a new writer frame picking any unowned buffer.
  task automatic model_edge(input bit i_en, input bit i_ws, input bit i_we,
                            input bit i_wa, input bit i_rs, input bit i_rst);
    bit was_idle, bypass;
    bit owned[4];
    if (i_rst) begin
      m_active = 0; m_rd_v = 0; m_ready_v = 0;
      m_wr = 0; m_rd = 0; m_ready = 0; m_drop = 0; m_shown = 0;
      return;
    end
    was_idle = !m_active;
    bypass = 0;
    if (m_active) begin
      if (i_wa) begin
        m_drop = sat(m_drop);
        m_active = 0;
      end else if (i_we) begin
        if (m_ready_v) m_drop = sat(m_drop);
        if (i_rs) begin
          bypass = 1;
          m_rd = m_wr; m_rd_v = 1; m_ready_v = 0;
          m_shown = sat(m_shown);
        end else begin
          m_ready = m_wr; m_ready_v = 1;
        end
        m_active = 0;
      end else if (i_ws) begin
        m_drop = sat(m_drop);
      end
    end
    if (i_rs && !bypass && m_ready_v) begin
      m_rd = m_ready; m_rd_v = 1; m_ready_v = 0;
      m_shown = sat(m_shown);
    end
    if (was_idle && i_ws && i_en) begin
      for (int i = 0; i < 4; i++) owned[i] = 0;
      if (m_rd_v) owned[m_rd] = 1;
      if (m_ready_v) owned[m_ready] = 1;
      for (int i = 2; i >= 0; i--) if (!owned[i]) m_wr = i;
      m_active = 1;
    end
  endtask

  task automatic step(input bit i_en, input bit i_ws, input bit i_we,
                      input bit i_wa, input bit i_rs, input bit i_rst);
    en = i_en; ws = i_ws; we = i_we; wa = i_wa; rs = i_rs; rst = i_rst;
    @(posedge clk);
    model_edge(i_en, i_ws, i_we, i_wa, i_rs, i_rst);
    #1;
    ws = 0; we = 0; wa = 0; rs = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    total++;
    if ({wr_valid, rd_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_valids got=%b exp=%b", {wr_valid, rd_valid}, 2'b00);
    end
    total++;
    if ({wr_base, rd_base, wr_idx, rd_idx} !== 68'h0) begin
      bad++; $display("FAIL reset_bases got=%h/%h exp=0/0", wr_base, rd_base);
    end
    total++;
    if ({dropped, shown} !== 32'h0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", dropped, shown);
    end
    step(1, 1, 0, 0, 0, 0);
    total++;
    if ({wr_valid, wr_idx, wr_base} !== {1'b1, 2'd0, 32'h0}) begin
      bad++; $display("FAIL reset_first_start got=%b/%0d/%h exp=1/0/0", wr_valid, wr_idx, wr_base);
    end
  endtask

  task automatic test_first_frame();
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    total++;
    if ({rd_valid, rd_idx, rd_base, shown} !== {1'b1, 2'd0, 32'h0, 16'd1}) begin
      bad++; $display("FAIL first_read got=%b/%0d/%h/%0d exp=1/0/0/1", rd_valid, rd_idx, rd_base, shown);
    end
    step(1, 1, 0, 0, 0, 0);
    total++;
    if ({wr_valid, wr_idx, wr_base} !== {1'b1, 2'd1, 32'h0004_B000}) begin
      bad++; $display("FAIL second_write got=%b/%0d/%h exp=1/1/0004b000", wr_valid, wr_idx, wr_base);
    end
  endtask

  task automatic test_writer_faster();
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    total++;
    if (wr_idx !== 2'd2) begin
      bad++; $display("FAIL wf_third_idx got=%0d exp=2", wr_idx);
    end
    step(1, 0, 1, 0, 0, 0);
    total++;
    if (dropped !== 16'd1) begin
      bad++; $display("FAIL wf_dropped got=%0d exp=1", dropped);
    end
    step(1, 0, 0, 0, 1, 0);
    total++;
    if ({rd_idx, rd_base, shown} !== {2'd2, 32'h0009_6000, 16'd2}) begin
      bad++; $display("FAIL wf_read got=%0d/%h/%0d exp=2/00096000/2", rd_idx, rd_base, shown);
    end
  endtask

  task automatic test_reader_faster();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1, 0);
      total++;
      if ({rd_valid, rd_base, shown} !== {1'b1, 32'h0009_6000, 16'd2}) begin
        bad++; $display("FAIL rf_repeat%0d got=%b/%h/%0d exp=1/00096000/2", k, rd_valid, rd_base, shown);
      end
    end
    step(0, 1, 0, 0, 0, 0);
    total++;
    if (wr_valid !== 1'b0) begin
      bad++; $display("FAIL rf_disabled_start got=%b exp=0", wr_valid);
    end
  endtask

  task automatic test_same_cycle();
    int d0, s0;
    step(1, 1, 0, 0, 0, 0);   // idx0
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);   // reader on 0
    step(1, 1, 0, 0, 0, 0);   // idx1
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);   // idx2
    step(1, 0, 1, 0, 0, 0);   // READY=2, 1 dropped
    step(1, 1, 0, 0, 0, 0);   // idx1
    total++;
    if (wr_idx !== 2'd1) begin
      bad++; $display("FAIL sc_setup_idx got=%0d exp=1", wr_idx);
    end
    d0 = m_drop; s0 = m_shown;
    step(1, 0, 1, 0, 1, 0);
    total++;
    if ({rd_idx, rd_base, dropped, shown} !== {2'd1, 32'h0004_B000, 16'(d0 + 1), 16'(s0 + 1)}) begin
      bad++; $display("FAIL sc_bypass got=%0d/%h/%0d/%0d exp=1/0004b000/%0d/%0d",
                      rd_idx, rd_base, dropped, shown, d0 + 1, s0 + 1);
    end
    step(1, 1, 0, 0, 0, 0);
    total++;
    if ({wr_valid, wr_idx} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL sc_next_start got=%b/%0d exp=1/0", wr_valid, wr_idx);
    end
    step(1, 0, 0, 0, 1, 0);
    total++;
    if ({rd_idx, shown} !== {2'd1, 16'(s0 + 1)}) begin
      bad++; $display("FAIL sc_ready_empty got=%0d/%0d exp=1/%0d", rd_idx, shown, s0 + 1);
    end
  endtask

  task automatic test_abort_saturation();
    int d0, s0;
    d0 = m_drop; s0 = m_shown;
    step(1, 0, 0, 1, 0, 0);
    total++;
    if ({wr_valid, dropped} !== {1'b0, 16'(d0 + 1)}) begin
      bad++; $display("FAIL ab_abort got=%b/%0d exp=0/%0d", wr_valid, dropped, d0 + 1);
    end
    step(1, 0, 0, 0, 1, 0);
    total++;
    if ({rd_idx, shown} !== {2'd1, 16'(s0)}) begin
      bad++; $display("FAIL ab_nothing_published got=%0d/%0d exp=1/%0d", rd_idx, shown, s0);
    end
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 65540; k++) step(1, 1, 0, 0, 0, 0);
    total++;
    if ({wr_valid, dropped} !== {1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL ab_saturate got=%b/%h exp=1/ffff", wr_valid, dropped);
    end
    step(1, 0, 0, 1, 0, 0);
    total++;
    if ({wr_valid, dropped} !== {1'b0, 16'hFFFF}) begin
      bad++; $display("FAIL ab_saturate_hold got=%b/%h exp=0/ffff", wr_valid, dropped);
    end
  endtask

  task automatic test_start_with_read();
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);   // idx0
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);   // reader on 0
    step(1, 1, 0, 0, 0, 0);   // idx1
    step(1, 0, 1, 0, 0, 0);   // READY=1
    step(1, 1, 0, 0, 1, 0);
    total++;
    if ({rd_idx, wr_idx, wr_base} !== {2'd1, 2'd0, 32'h0}) begin
      bad++; $display("FAIL swr_post_update got=rd%0d/wr%0d/%h exp=rd1/wr0/0", rd_idx, wr_idx, wr_base);
    end
  endtask

  task automatic test_back_to_back();
    logic [101:0] got, exp;
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < 85, $urandom_range(99) < 30, $urandom_range(99) < 25,
           $urandom_range(99) < 5, $urandom_range(99) < 25, $urandom_range(999) < 5);
      got = {wr_valid, rd_valid, wr_idx, rd_idx, wr_base, rd_base, dropped, shown};
      exp = {m_active, m_rd_v, 2'(m_wr), 2'(m_rd), base_of(m_wr), base_of(m_rd),
             16'(m_drop), 16'(m_shown)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_cycle%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_writer_faster();
    test_reader_faster();
    test_same_cycle();
    test_abort_saturation();
    test_start_with_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
